// File: rtl/plru_eviction_policy.sv
// Eviction-policy responder for one cache set: per-way valid bits plus a
// binary-tree pseudo-LRU, answering miss requests with a held one-hot victim.
module plru_eviction_policy #(
    parameter int NUM_WAYS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_WAYS-1:0] hitWay,
    input  logic                hit,
    input  logic [NUM_WAYS-1:0] missWay,
    input  logic                miss,
    input  logic [NUM_WAYS-1:0] allocateWay,
    input  logic                allocate,
    output logic [NUM_WAYS-1:0] evictionTarget,
    output logic                evictionReady
);
    localparam int LEVELS = $clog2(NUM_WAYS);
    localparam int NODES  = NUM_WAYS - 1;

    typedef enum logic [1:0] {IDLE, SEARCH, READY} state_t;

    state_t              state_reg;
    logic [NODES-1:0]    tree_reg;
    logic [NODES-1:0]    tree_next;
    logic [NUM_WAYS-1:0] valid_reg;
    logic [NUM_WAYS-1:0] valid_next;
    logic [NUM_WAYS-1:0] victim;
    logic [NUM_WAYS-1:0] victim_reg;
    logic [NUM_WAYS-1:0] target_reg;
    logic                ready_reg;
    logic                hit_ok;
    logic                alloc_ok;
    logic [LEVELS-1:0]   hit_idx;
    logic [LEVELS-1:0]   alloc_idx;
    logic                found;
    int                  node;
    logic                unused_miss_way;

    assign unused_miss_way = ^missWay;

    // Malformed strobes (zero or several bits) are dropped entirely.
    assign hit_ok   = hit && $onehot(hitWay);
    assign alloc_ok = allocate && $onehot(allocateWay);

    always_comb begin
        hit_idx   = '0;
        alloc_idx = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (hitWay[w])      hit_idx   = LEVELS'(w);
            if (allocateWay[w]) alloc_idx = LEVELS'(w);
        end
    end

    // Each node is rewritten only when the touched way lies beneath it;
    // the allocate touch has priority over a concurrent hit touch.
    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_level
        for (genvar gj = 0; gj < (1 << gi); gj++) begin : g_node
            localparam int NODE  = (1 << gi) - 1 + gj;
            localparam int SHIFT = LEVELS - gi;
            logic hit_on;
            logic alloc_on;
            assign hit_on   = hit_ok   && (32'(hit_idx   >> SHIFT) == gj);
            assign alloc_on = alloc_ok && (32'(alloc_idx >> SHIFT) == gj);
            assign tree_next[NODE] = alloc_on ? ~alloc_idx[SHIFT-1] :
                                     hit_on   ? ~hit_idx[SHIFT-1]   :
                                                tree_reg[NODE];
        end
    end

    assign valid_next = valid_reg | (alloc_ok ? allocateWay : '0);

    always_comb begin
        victim = '0;
        found  = 1'b0;
        node   = 0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid_reg[w] && !found) begin
                victim[w] = 1'b1;
                found     = 1'b1;
            end
        end
        if (!found) begin
            for (int l = 0; l < LEVELS; l++) begin
                node = 2 * node + 1 + int'(tree_reg[node]);
            end
            victim[node - NODES] = 1'b1;
        end
    end

    // The SEARCH edge snapshots the victim from pre-edge state, so touches
    // landing on that same edge are excluded; the outputs follow one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            tree_reg   <= '0;
            valid_reg  <= '0;
            victim_reg <= '0;
            target_reg <= '0;
            ready_reg  <= 1'b0;
        end else begin
            tree_reg  <= tree_next;
            valid_reg <= valid_next;
            case (state_reg)
                IDLE: begin
                    if (miss) state_reg <= SEARCH;
                end
                SEARCH: begin
                    victim_reg <= victim;
                    state_reg  <= READY;
                end
                READY: begin
                    if (!ready_reg) begin
                        target_reg <= victim_reg;
                        ready_reg  <= 1'b1;
                    end else if (alloc_ok) begin
                        target_reg <= '0;
                        ready_reg  <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign evictionTarget = target_reg;
    assign evictionReady  = ready_reg;
endmodule

// File: tb/tb_plru_eviction_policy.sv
// Directed bench for a 4-way plru_eviction_policy with a queue of expected victims.
module tb_plru_eviction_policy;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] hitWay, missWay, allocateWay;
    logic         hit, miss, allocate;
    logic [W-1:0] evictionTarget;
    logic         evictionReady;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sb[$];

    plru_eviction_policy #(.NUM_WAYS(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .hitWay(hitWay), .hit(hit),
        .missWay(missWay), .miss(miss),
        .allocateWay(allocateWay), .allocate(allocate),
        .evictionTarget(evictionTarget), .evictionReady(evictionReady)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_miss(input logic [W-1:0] exp);
        int cnt;
        sb.push_back(exp);
        @(negedge clk);
        miss = 1'b1;
        @(posedge clk);
        #1 miss = 1'b0;
        cnt = 0;
        while (!evictionReady && cnt < 10) begin
            @(posedge clk);
            #1 cnt++;
        end
        check("miss_latency", 32'(cnt), 32'd2);
        check("miss_target", 32'(evictionTarget), 32'(sb.pop_front()));
    endtask

    task automatic do_alloc(input logic [W-1:0] way, input logic completes);
        logic [W-1:0] tgt_before;
        tgt_before = evictionTarget;
        @(negedge clk);
        allocateWay = way;
        allocate    = 1'b1;
        @(posedge clk);
        #1 allocate = 1'b0;
        check("alloc_ready", 32'(evictionReady), completes ? 32'd0 : 32'd1);
        check("alloc_target", 32'(evictionTarget), completes ? 32'd0 : 32'(tgt_before));
    endtask

    task automatic do_hit(input logic [W-1:0] way);
        @(negedge clk);
        hitWay = way;
        hit    = 1'b1;
        @(posedge clk);
        #1 hit = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        hit = 1'b0; miss = 1'b0; allocate = 1'b0;
        hitWay = '0; missWay = '0; allocateWay = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(evictionReady), 32'd0);
        check("reset_target", 32'(evictionTarget), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // First miss, held output, then fill the remaining ways.
        do_miss(4'b0001);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_ready", 32'(evictionReady), 32'd1);
            check("hold_target", 32'(evictionTarget), 32'b0001);
        end
        do_alloc(4'b0001, 1'b1);
        do_miss(4'b0010);
        do_alloc(4'b0010, 1'b1);
        do_miss(4'b0100);
        do_alloc(4'b0100, 1'b1);
        do_miss(4'b1000);
        do_alloc(4'b1000, 1'b1);
        do_miss(4'b0001);
        do_alloc(4'b0001, 1'b1);

        // Hits steer the tree away from ways 0 and 2.
        do_hit(4'b0001);
        do_hit(4'b0100);
        do_miss(4'b0010);
        do_alloc(4'b0010, 1'b1);

        // Concurrent hit and allocate: allocate wins the shared root.
        @(negedge clk);
        hitWay = 4'b0001; hit = 1'b1;
        allocateWay = 4'b1000; allocate = 1'b1;
        @(posedge clk);
        #1 hit = 1'b0; allocate = 1'b0;
        do_miss(4'b0010);
        do_alloc(4'b0010, 1'b1);

        // Reset in READY drops outputs without a clock edge.
        do_miss(4'b0100);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(evictionReady), 32'd0);
        check("async_rst_target", 32'(evictionTarget), 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        do_miss(4'b0001);

        // READY ignores hits, repeated misses and malformed allocates.
        do_hit(4'b0001);
        check("ready_hit_target", 32'(evictionTarget), 32'b0001);
        check("ready_hit_ready", 32'(evictionReady), 32'd1);
        @(negedge clk);
        miss = 1'b1;
        @(posedge clk);
        #1 miss = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("second_miss_ready", 32'(evictionReady), 32'd1);
        check("second_miss_target", 32'(evictionTarget), 32'b0001);
        do_alloc(4'b0011, 1'b0);
        do_alloc(4'b0001, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_ready", 32'(evictionReady), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
